// File: rtl/multiplier_seq.sv
// -----------------------------------------------------------------------------
// multiplier_seq
//
// Sequential unsigned shift-and-add multiplier that retires one multiplier bit
// per clock. Two WIDTH-bit operands are captured on an accepted start. After
// WIDTH iterations the exact 2*WIDTH-bit product is written to the result
// register and a one-cycle done pulse is raised. This block is the counterpart
// of the sequential restoring divider in the arithmetic datapath.
//
// Ports
//   clk      in   1         rising-edge clock
//   reset    in   1         asynchronous, active-low reset (0 = reset)
//   start    in   1         request; sampled only while idle
//   mcand    in   WIDTH     multiplicand, captured on the accepting edge
//   mplier   in   WIDTH     multiplier, captured on the accepting edge
//   busy     out  1         high while iterating
//   done     out  1         one-cycle pulse when the product is written
//   product  out  2*WIDTH   result register; holds until the next completion
//
// Timing
//   The start is accepted at edge E0 and the iterations run on edges E1..E_WIDTH.
//   done is high during the cycle that follows E_WIDTH. Throughput is one
//   operation every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mc_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]   acc_next;

    // One iteration of the datapath. The upper half of acc holds the running
    // partial product. The lower half holds the multiplier bits that have not
    // been consumed yet, and acc[0] is always the current multiplier bit. The
    // add is one bit wider than the operands so that the carry is shifted back
    // into the top of acc rather than lost. This keeps the product exact.
    always_comb begin
        addend   = acc[0] ? mc_reg : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    // Control FSM with registered busy/done. All state, including the datapath
    // registers, is cleared by reset. An abort mid-run therefore leaves no
    // stale operands behind and produces no done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mc_reg  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mc_reg <= mcand;
                        acc    <= {{WIDTH{1'b0}}, mplier};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // On the last iteration, publish the freshly shifted accumulator.
                    // cnt may wrap here, which is harmless because RUN is being left.
                    if (cnt == CNT_LAST) begin
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    // start is not sampled here. Only IDLE may accept a new operation.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
